// File: rtl/fs4_serial_pkg.sv
// Shared constants and types for the bit-serial subtractor.
// State encoding is fixed so other arithmetic blocks can decode it directly.
package fs4_serial_pkg;

    localparam int FS_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fs4_serial_if.sv
// Request/result bundle for fs4_serial: operands and start in, status and result out.
interface fs4_serial_if
    import fs4_serial_pkg::*;
#(
    parameter int WIDTH = FS_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo
    );
endinterface

// File: rtl/fs4_serial_fs.sv
// 1-bit full subtractor cell: d = a - b - bi, bo = borrow out.
// Purely combinational, no state and no flow control.
module fs (
    output logic d,
    output logic bo,
    input  logic a,
    input  logic b,
    input  logic bi
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/fs4_serial.sv
// Bit-serial subtractor {bo,d} = a - b - bi, LSB first through one fs cell.
// Latency: WIDTH cycles busy after the accepting edge, then a 1-cycle done pulse.
// Backpressure: start is ignored while busy; it is accepted in IDLE and in DONE.
module fs4_serial
    import fs4_serial_pkg::*;
#(
    parameter int WIDTH = FS_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    fs4_serial_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [WIDTH-1:0] d_q;
    logic             bo_q;
    logic             load;
    logic             step;
    logic             last;
    logic             di;
    logic             br_nxt;

    fs u_fs (
        .d  (di),
        .bo (br_nxt),
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (br)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Difference bits enter the minuend register at the MSB as its LSBs are
    // consumed, so after WIDTH steps it holds the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            br    <= 1'b0;
            d_q   <= '0;
            bo_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_sr <= bus.a;
                b_sr <= bus.b;
                br   <= bus.bi;
                cnt  <= '0;
            end else if (step) begin
                a_sr <= {di, a_sr[WIDTH-1:1]};
                b_sr <= b_sr >> 1;
                br   <= br_nxt;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    d_q  <= {di, a_sr[WIDTH-1:1]};
                    bo_q <= br_nxt;
                end
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
endmodule

// File: doc/fs4_serial.md
# fs4_serial

Bit-serial subtractor, the sequential counterpart of the 4-bit ripple adder in the arithmetic library. Accepts two WIDTH-bit operands and a borrow-in on a start strobe and computes `d = a - b - bi` one bit per clock, LSB first, through a single full-subtractor cell. It presents the registered difference and borrow-out with a one-cycle done pulse. Intended for area-constrained datapaths where one subtraction every WIDTH+1 cycles is sufficient.

## Interface
- WIDTH, 4, operand/result width in bits; legal range ≥ 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- a  in  WIDTH  minuend; captured on accepted start.
- b  in  WIDTH  subtrahend; captured on accepted start.
- bi  in  1  borrow in; captured on accepted start.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse; d/bo valid.
- d  out  WIDTH  difference (a - b - bi) mod 2^WIDTH.
- bo  out  1  borrow out; 1 when a < b + bi (unsigned).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → latch a, b, bi into internal shift registers and borrow flop; clear bit counter; go to SHIFT.
- SHIFT, one bit per cycle, bit i = counter value:
  - `di = ai ^ bi_op ^ br`
  - `br' = (~ai & bi_op) | (~(ai ^ bi_op) & br)`
  - Shift di into the result register MSB-ward; increment counter.
  - Counter = WIDTH-1 → copy result to d and final borrow to bo; go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 → accepted as in IDLE (back-to-back), next state SHIFT.
  - Otherwise → IDLE.
- start while busy=1 is ignored; no queuing, operands not re-sampled.
- d and bo are updated only on completion. They hold the previous result throughout SHIFT and IDLE until the next completion.
- Arithmetic is unsigned modulo 2^WIDTH. bo is the borrow out of the MSB; {bo, d} equals the (WIDTH+1)-bit two's-complement result of a - b - bi.

## Timing
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, d=0, bo=0, counter=0, internal registers 0. Reset overrides start.
- Reset mid-SHIFT aborts the operation: no done pulse, d/bo cleared to 0.
- Latency: start accepted at edge E0. busy=1 after E0 through E_WIDTH (WIDTH cycles). done=1 and busy=0 in the cycle after E_WIDTH; d/bo valid in that same cycle.
- Throughput: with start held high, one result per WIDTH+1 cycles.
- busy and done are never high together. done is never high in two consecutive cycles.
- Operand inputs may change freely after the accepting edge.

## Structure
- Shared arithmetic package:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default width constant FS_WIDTH=4.
  - Counter width `$clog2(WIDTH)`.
- One sub-module: `fs`, a combinational 1-bit full subtractor.
  - Ports: d, bo, a, b, bi.
  - Mirrors the existing full-adder cell and is reusable by a future parallel subtractor.
- Top level holds the FSM, counter, operand shift registers, borrow flop and result registers.

## Test plan
- Reset, then a=9, b=3, bi=0, start one cycle → busy 4 cycles, then done with d=6, bo=0.
- a=3, b=9, bi=0 → d=4'hA, bo=1. a=0, b=0, bi=1 → d=4'hF, bo=1. a=15, b=15, bi=0 → d=0, bo=0.
- start re-pulsed with a=1, b=1 during busy → ignored; first result (a=12, b=5 → d=7, bo=0) delivered unchanged at the expected cycle.
- start held high continuously with fixed operands 8 - 1 → done every 5 cycles, d=7 each time, busy low only in done cycles.
- rst asserted 2 cycles into SHIFT → next cycle busy=0, d=0, bo=0; no done pulse follows. A fresh start then completes normally.
- Exhaustive sweep of all a, b, bi (WIDTH=4) → {bo, d} matches the reference model (a - b - bi) for all 512 cases.
